// File: rtl/bus_arbiter_ctrl_pkg.sv
// Shared definitions for the two-master / five-slave bus controller.
//   - arb_state_t : arbiter state encoding
//   - NUM_SLAVES  : number of decoded slaves
//   - RD_*        : read-data mux select codes (000 = zero, 001..101 = slave 0..4)
//   - rd_code()   : slave index -> read-data select code
package bus_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam int NUM_SLAVES = 5;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_S0   = 3'b001;
    localparam logic [2:0] RD_S1   = 3'b010;
    localparam logic [2:0] RD_S2   = 3'b011;
    localparam logic [2:0] RD_S3   = 3'b100;
    localparam logic [2:0] RD_S4   = 3'b101;

    // Slave i is routed on mux input i+1; input 0 is tied to zero.
    function automatic logic [2:0] rd_code(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/bus_arbiter_ctrl_addr_decoder.sv
// Combinational slave decoder.
//   idx    in  3           slave-index field of the bus address
//   en     in  1           a master currently owns the bus
//   s_sel  out NUM_SLAVES  one-hot slave select (all zero when disabled/unmapped)
//   mapped out 1           idx addresses an existing slave
module addr_decoder
    import bus_arbiter_ctrl_pkg::*;
(
    input  logic [2:0]            idx,
    input  logic                  en,
    output logic [NUM_SLAVES-1:0] s_sel,
    output logic                  mapped
);

    always_comb begin
        mapped = (idx < 3'(NUM_SLAVES));
        s_sel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_sel[i] = en && mapped && (idx == 3'(i));
        end
    end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Bus controller for two masters sharing one bus to five slaves.
// Arbitrates ownership (alternating tie-break, bounded hold while the other
// master waits), drives the master mux select, decodes the slave select and
// registers the read-data mux select one cycle behind the address phase.
//   clk, reset        clock, synchronous active-high reset
//   m0_req, m1_req    master requests (held for the whole tenure)
//   bus_addr, bus_wr  muxed address and write strobe
//   m0_grant/m1_grant registered ownership
//   m_sel             master mux select (0 = M0, 1 = M1), held through IDLE
//   s_sel             combinational one-hot slave select
//   rd_sel            registered read-data mux select
// Handshake: a master owns the bus for every cycle its grant is high; the
// grant follows the request with one cycle of latency, and a request must be
// held until the grant is observed and for the whole transfer sequence.
module bus_arbiter_ctrl
    import bus_arbiter_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DEC_LSB  = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic                  bus_wr,
    output logic                  m0_grant,
    output logic                  m1_grant,
    output logic                  m_sel,
    output logic [NUM_SLAVES-1:0] s_sel,
    output logic [2:0]            rd_sel
);

    arb_state_t state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       last_owner_q, last_owner_d;   // 0 = M0, 1 = M1
    logic       m0_grant_q, m0_grant_d;
    logic       m1_grant_q, m1_grant_d;
    logic       m_sel_q, m_sel_d;
    logic [2:0] rd_sel_q, rd_sel_d;

    logic [2:0] idx;
    logic       mapped;
    logic       grant_active;
    logic       at_max;
    logic       other_req;

    // Only the slave-index field is decoded; the rest of the address belongs
    // to the slaves.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_addr[ADDR_W-1:DEC_LSB+3], bus_addr[DEC_LSB-1:0]};

    assign idx          = bus_addr[DEC_LSB+2:DEC_LSB];
    assign grant_active = (state_q != IDLE);
    assign at_max       = (hold_cnt_q == 8'(MAX_HOLD - 1));

    addr_decoder u_dec (
        .idx    (idx),
        .en     (grant_active),
        .s_sel  (s_sel),
        .mapped (mapped)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) state_d = last_owner_q ? GNT0 : GNT1;
                else if (m0_req)      state_d = GNT0;
                else if (m1_req)      state_d = GNT1;
            end
            GNT0: begin
                if (!m0_req)             state_d = m1_req ? GNT1 : IDLE;
                else if (m1_req && at_max) state_d = GNT1;
            end
            GNT1: begin
                if (!m1_req)             state_d = m0_req ? GNT0 : IDLE;
                else if (m0_req && at_max) state_d = GNT0;
            end
            default: state_d = IDLE;
        endcase

        // Counts only cycles in which the other master is kept waiting.
        other_req  = (state_q == GNT0) ? m1_req : m0_req;
        hold_cnt_d = '0;
        if (state_d == state_q && state_q != IDLE) begin
            if (other_req && !at_max) hold_cnt_d = hold_cnt_q + 8'd1;
            else                      hold_cnt_d = hold_cnt_q;
        end

        last_owner_d = last_owner_q;
        if (state_d != state_q) begin
            if (state_d == GNT0) last_owner_d = 1'b0;
            if (state_d == GNT1) last_owner_d = 1'b1;
        end

        m0_grant_d = (state_d == GNT0);
        m1_grant_d = (state_d == GNT1);
        m_sel_d    = (state_d == GNT1) ? 1'b1 :
                     (state_d == GNT0) ? 1'b0 : m_sel_q;

        rd_sel_d = (grant_active && !bus_wr && mapped) ? rd_code(idx) : RD_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            last_owner_q <= 1'b1;
            m0_grant_q   <= 1'b0;
            m1_grant_q   <= 1'b0;
            m_sel_q      <= 1'b0;
            rd_sel_q     <= RD_NONE;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            m0_grant_q   <= m0_grant_d;
            m1_grant_q   <= m1_grant_d;
            m_sel_q      <= m_sel_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

    assign m0_grant = m0_grant_q;
    assign m1_grant = m1_grant_q;
    assign m_sel    = m_sel_q;
    assign rd_sel   = rd_sel_q;

endmodule
